hit_judge: RTL and testbench

HIT_JUDGE -- requirements
Module: hit_judge

---
 rtl/boxing_pkg.sv | 23 ++
 rtl/punch_edge_det.sv | 33 +++
 rtl/hit_judge.sv | 144 ++++++++++++++
 tb/tb_hit_judge.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/boxing_pkg.sv
// Shared encodings for the boxing hit judge: player action states, winner codes
// and the judge FSM states.
package boxing_pkg;

  typedef enum logic [1:0] {
    NOTHING  = 2'b00,
    DEF      = 2'b01,
    ATK      = 2'b10,
    PUNCHING = 2'b11
  } action_e;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;
  localparam logic [1:0] WIN_DRAW = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FIGHT = 2'b01,
    OVER  = 2'b10
  } judge_state_e;

endpackage

// File: rtl/punch_edge_det.sv
// Two-flop synchronizer for one player's action state plus a detector that
// fires once when the synchronized state enters PUNCHING.
module punch_edge_det
  import boxing_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_state,
  output logic [1:0] o_sync,
  output logic       o_punch
);

  logic [1:0] r_meta;
  logic [1:0] r_sync;
  logic [1:0] r_prev;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_meta <= 2'b00;
      r_sync <= 2'b00;
      r_prev <= 2'b00;
    end else begin
      r_meta <= i_state;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_sync  = r_sync;
  // A held PUNCHING state only counts on its first synchronized cycle.
  assign o_punch = (r_sync == PUNCHING) && (r_prev != PUNCHING);

endmodule

// File: rtl/hit_judge.sv
// Two-player hit judge: scores punches, detects blocks, and decides the winner.
// Optional macro HIT_JUDGE_DOUBLE_KO_EN lets simultaneous punches both score.
module hit_judge
  import boxing_pkg::*;
#(
  parameter int WIN_SCORE = 5,
  parameter int SCORE_W   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [1:0]         p1_state,
  input  logic [1:0]         p2_state,
  output logic [SCORE_W-1:0] p1_score,
  output logic [SCORE_W-1:0] p2_score,
  output logic               hit1,
  output logic               hit2,
  output logic               blk1,
  output logic               blk2,
  output logic [1:0]         winner,
  output logic               fighting,
  output judge_state_e       o_dbg_state
);

  localparam logic [SCORE_W-1:0] W_WIN = SCORE_W'(WIN_SCORE);
  localparam logic [SCORE_W-1:0] W_ONE = SCORE_W'(1);

  logic [1:0] w_p1_sync;
  logic [1:0] w_p2_sync;
  logic       w_p1_punch;
  logic       w_p2_punch;
  logic       w_cancel;
  logic       w_p1_go;
  logic       w_p2_go;
  logic       w_p1_won;
  logic       w_p2_won;

  judge_state_e       r_state;
  logic [SCORE_W-1:0] r_p1_score;
  logic [SCORE_W-1:0] r_p2_score;
  logic               r_hit1;
  logic               r_hit2;
  logic               r_blk1;
  logic               r_blk2;
  logic [1:0]         r_winner;
  logic               r_fighting;

  punch_edge_det u_p1_det (
    .clk     (clk),
    .rst     (rst),
    .i_state (p1_state),
    .o_sync  (w_p1_sync),
    .o_punch (w_p1_punch)
  );

  punch_edge_det u_p2_det (
    .clk     (clk),
    .rst     (rst),
    .i_state (p2_state),
    .o_sync  (w_p2_sync),
    .o_punch (w_p2_punch)
  );

`ifdef HIT_JUDGE_DOUBLE_KO_EN
  assign w_cancel = 1'b0;
`else
  assign w_cancel = w_p1_punch & w_p2_punch;
`endif

  assign w_p1_go  = w_p1_punch & ~w_cancel;
  assign w_p2_go  = w_p2_punch & ~w_cancel;
  assign w_p1_won = (r_p1_score == W_WIN);
  assign w_p2_won = (r_p2_score == W_WIN);

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
    return (s >= W_WIN) ? s : s + W_ONE;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_p1_score <= '0;
      r_p2_score <= '0;
      r_hit1     <= 1'b0;
      r_hit2     <= 1'b0;
      r_blk1     <= 1'b0;
      r_blk2     <= 1'b0;
      r_winner   <= WIN_NONE;
      r_fighting <= 1'b0;
    end else begin
      r_hit1 <= 1'b0;
      r_hit2 <= 1'b0;
      r_blk1 <= 1'b0;
      r_blk2 <= 1'b0;
      // Start wins over any punch seen in the same cycle.
      if (start) begin
        r_state    <= FIGHT;
        r_p1_score <= '0;
        r_p2_score <= '0;
        r_winner   <= WIN_NONE;
        r_fighting <= 1'b1;
      end else begin
        case (r_state)
          FIGHT: begin
            if (w_p1_won || w_p2_won) begin
              r_state    <= OVER;
              r_fighting <= 1'b0;
              r_winner   <= {w_p2_won, w_p1_won};
            end else begin
              if (w_p1_go) begin
                if (w_p2_sync == DEF) begin
                  r_blk1 <= 1'b1;
                end else begin
                  r_hit1     <= 1'b1;
                  r_p1_score <= sat_inc(r_p1_score);
                end
              end
              if (w_p2_go) begin
                if (w_p1_sync == DEF) begin
                  r_blk2 <= 1'b1;
                end else begin
                  r_hit2     <= 1'b1;
                  r_p2_score <= sat_inc(r_p2_score);
                end
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign p1_score    = r_p1_score;
  assign p2_score    = r_p2_score;
  assign hit1        = r_hit1;
  assign hit2        = r_hit2;
  assign blk1        = r_blk1;
  assign blk2        = r_blk2;
  assign winner      = r_winner;
  assign fighting    = r_fighting;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_hit_judge.sv
// Self-checking bench for hit_judge: pulse events are matched against an
// expected queue of {cycle, {hit1,hit2,blk1,blk2}} entries.
module tb_hit_judge;

  logic       clk;
  logic       rst;
  logic       start;
  logic [1:0] p1_state;
  logic [1:0] p2_state;
  logic [3:0] p1_score;
  logic [3:0] p2_score;
  logic       hit1, hit2, blk1, blk2;
  logic [1:0] winner;
  logic       fighting;
  logic [1:0] dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [19:0] exp_q[$];
  logic [19:0] obs_q[$];
  logic [19:0] e, o;

  hit_judge #(.WIN_SCORE(5), .SCORE_W(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .p1_state    (p1_state),
    .p2_state    (p2_state),
    .p1_score    (p1_score),
    .p2_score    (p2_score),
    .hit1        (hit1),
    .hit2        (hit2),
    .blk1        (blk1),
    .blk2        (blk2),
    .winner      (winner),
    .fighting    (fighting),
    .o_dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // pulse monitor
  always @(negedge clk) begin
    if ({hit1, hit2, blk1, blk2} != 4'b0000)
      obs_q.push_back({16'(cyc), hit1, hit2, blk1, blk2});
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

  // driver tasks
  task automatic set_states(input logic [1:0] s1, input logic [1:0] s2);
    @(negedge clk);
    p1_state = s1;
    p2_state = s2;
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic punch(input logic [1:0] s1, input logic [1:0] s2,
                       input logic [1:0] r1, input logic [1:0] r2,
                       input logic [3:0] exp_vec);
    int c0;
    @(negedge clk);
    p1_state = s1;
    p2_state = s2;
    c0 = cyc;
    if (exp_vec != 4'b0000) exp_q.push_back({16'(c0 + 3), exp_vec});
    repeat (4) @(negedge clk);
    p1_state = r1;
    p2_state = r2;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; p1_state = 2'b00; p2_state = 2'b00;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({p1_score, p2_score} !== 8'h00) begin
      n_fail++; $display("FAIL reset_scores: got %h, expected 00", {p1_score, p2_score});
    end
    n_checks++;
    if ({hit1, hit2, blk1, blk2, winner, fighting} !== 7'b0) begin
      n_fail++; $display("FAIL reset_outputs: got %b, expected 0000000", {hit1, hit2, blk1, blk2, winner, fighting});
    end
    n_checks++;
    if (dbg_state !== 2'b00) begin
      n_fail++; $display("FAIL reset_state: got %b, expected 00", dbg_state);
    end
    rst = 1'b1;
    // Punches before any start are ignored.
    punch(2'b11, 2'b00, 2'b00, 2'b00, 4'b0000);
    #1;
    n_checks++;
    if (p1_score !== 4'd0) begin
      n_fail++; $display("FAIL idle_score: got %0d, expected 0", p1_score);
    end
    n_checks++;
    if (obs_q.size() != 0) begin
      n_fail++; $display("FAIL idle_pulse: got %0d pulse events, expected 0", obs_q.size()); obs_q.delete();
    end
  endtask

  task automatic test_hit_block();
    do_start();
    #1;
    n_checks++;
    if ({fighting, dbg_state} !== 3'b101) begin
      n_fail++; $display("FAIL start_fight: got %b, expected 101", {fighting, dbg_state});
    end
    punch(2'b11, 2'b00, 2'b00, 2'b00, 4'b1000);
    punch(2'b00, 2'b11, 2'b00, 2'b00, 4'b0100);
    set_states(2'b00, 2'b01);
    repeat (4) @(negedge clk);
    punch(2'b11, 2'b01, 2'b00, 2'b01, 4'b0010);
    set_states(2'b01, 2'b00);
    repeat (4) @(negedge clk);
    punch(2'b01, 2'b11, 2'b01, 2'b00, 4'b0001);
    set_states(2'b00, 2'b00);
    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if ({p1_score, p2_score} !== 8'h11) begin
      n_fail++; $display("FAIL hit_block_scores: got %h, expected 11", {p1_score, p2_score});
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin
        n_fail++; $display("FAIL hit_block_pulse: got none, expected cyc %0d vec %b", e[19:4], e[3:0]);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          n_fail++; $display("FAIL hit_block_pulse: got cyc %0d vec %b, expected cyc %0d vec %b", o[19:4], o[3:0], e[19:4], e[3:0]);
        end
      end
    end
    n_checks++;
    if (obs_q.size() != 0) begin
      n_fail++; $display("FAIL hit_block_extra: got %0d extra pulse events, expected 0", obs_q.size()); obs_q.delete();
    end
  endtask

  task automatic test_hold();
    int c0;
    do_start();
    @(negedge clk);
    p1_state = 2'b11;
    c0 = cyc;
    exp_q.push_back({16'(c0 + 3), 4'b1000});
    repeat (50) @(negedge clk);
    p1_state = 2'b00;
    repeat (4) @(negedge clk);
    #1;
    n_checks++;
    if (p1_score !== 4'd1) begin
      n_fail++; $display("FAIL hold_score: got %0d, expected 1", p1_score);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin
        n_fail++; $display("FAIL hold_pulse: got none, expected cyc %0d vec %b", e[19:4], e[3:0]);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          n_fail++; $display("FAIL hold_pulse: got cyc %0d vec %b, expected cyc %0d vec %b", o[19:4], o[3:0], e[19:4], e[3:0]);
        end
      end
    end
    n_checks++;
    if (obs_q.size() != 0) begin
      n_fail++; $display("FAIL hold_extra: got %0d extra pulse events, expected 0", obs_q.size()); obs_q.delete();
    end
  endtask

  task automatic test_win();
    do_start();
    for (int i = 0; i < 5; i++) punch(2'b11, 2'b00, 2'b00, 2'b00, 4'b1000);
    #1;
    n_checks++;
    if ({winner, fighting, dbg_state} !== 5'b01010) begin
      n_fail++; $display("FAIL win_over: got winner/fighting/state %b, expected 01010", {winner, fighting, dbg_state});
    end
    punch(2'b11, 2'b00, 2'b00, 2'b00, 4'b0000);
    #1;
    n_checks++;
    if ({p1_score, p2_score} !== 8'h50) begin
      n_fail++; $display("FAIL win_saturate: got %h, expected 50", {p1_score, p2_score});
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin
        n_fail++; $display("FAIL win_pulse: got none, expected cyc %0d vec %b", e[19:4], e[3:0]);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          n_fail++; $display("FAIL win_pulse: got cyc %0d vec %b, expected cyc %0d vec %b", o[19:4], o[3:0], e[19:4], e[3:0]);
        end
      end
    end
    n_checks++;
    if (obs_q.size() != 0) begin
      n_fail++; $display("FAIL win_extra: got %0d extra pulse events, expected 0", obs_q.size()); obs_q.delete();
    end
    do_start();
    #1;
    n_checks++;
    if ({winner, fighting, p1_score} !== 7'b0010000) begin
      n_fail++; $display("FAIL restart_clear: got %b, expected 0010000", {winner, fighting, p1_score});
    end
  endtask

  task automatic test_double();
    do_start();
    for (int i = 0; i < 4; i++) begin
      punch(2'b11, 2'b00, 2'b00, 2'b00, 4'b1000);
      punch(2'b00, 2'b11, 2'b00, 2'b00, 4'b0100);
    end
`ifdef HIT_JUDGE_DOUBLE_KO_EN
    punch(2'b11, 2'b11, 2'b00, 2'b00, 4'b1100);
    #1;
    n_checks++;
    if ({p1_score, p2_score, winner, fighting} !== 11'b0101_0101_11_0) begin
      n_fail++; $display("FAIL double_ko: got %b, expected 01010101110", {p1_score, p2_score, winner, fighting});
    end
`else
    punch(2'b11, 2'b11, 2'b00, 2'b00, 4'b0000);
    #1;
    n_checks++;
    if ({p1_score, p2_score, winner, fighting} !== 11'b0100_0100_00_1) begin
      n_fail++; $display("FAIL double_cancel: got %b, expected 01000100001", {p1_score, p2_score, winner, fighting});
    end
`endif
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin
        n_fail++; $display("FAIL double_pulse: got none, expected cyc %0d vec %b", e[19:4], e[3:0]);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          n_fail++; $display("FAIL double_pulse: got cyc %0d vec %b, expected cyc %0d vec %b", o[19:4], o[3:0], e[19:4], e[3:0]);
        end
      end
    end
    n_checks++;
    if (obs_q.size() != 0) begin
      n_fail++; $display("FAIL double_extra: got %0d extra pulse events, expected 0", obs_q.size()); obs_q.delete();
    end
  endtask

  task automatic test_reset_mid();
    do_start();
    punch(2'b11, 2'b00, 2'b00, 2'b00, 4'b1000);
    set_states(2'b11, 2'b00);
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++;
    if ({p1_score, p2_score, hit1, hit2, blk1, blk2, winner, fighting, dbg_state} !== 17'b0) begin
      n_fail++; $display("FAIL mid_reset_async: got %b, expected all zero",
                         {p1_score, p2_score, hit1, hit2, blk1, blk2, winner, fighting, dbg_state});
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (6) @(negedge clk);
    p1_state = 2'b00;
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if ({p1_score, fighting} !== 5'b0) begin
      n_fail++; $display("FAIL mid_reset_after: got %b, expected 00000", {p1_score, fighting});
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin
        n_fail++; $display("FAIL mid_reset_pulse: got none, expected cyc %0d vec %b", e[19:4], e[3:0]);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          n_fail++; $display("FAIL mid_reset_pulse: got cyc %0d vec %b, expected cyc %0d vec %b", o[19:4], o[3:0], e[19:4], e[3:0]);
        end
      end
    end
    n_checks++;
    if (obs_q.size() != 0) begin
      n_fail++; $display("FAIL mid_reset_extra: got %0d pulse events after reset, expected 0", obs_q.size()); obs_q.delete();
    end
  endtask

  initial begin
    test_reset();
    test_hit_block();
    test_hold();
    test_win();
    test_double();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
